// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage RV32I pipeline. Tracks the
//   instructions in EX, MEM and WB in a small scoreboard. Produces the PC and
//   stage-register enables and flushes, the EX forwarding selects, and the PC
//   redirect strobe. Freezes everything while data memory is busy.
//
// Ports
//   clk, rst (sync, active low)
//   id_*          decoded fields of the instruction held in IF/ID
//   ex_redirect   taken branch/jump resolved in EX (one-cycle pulse)
//   mem_busy      data memory not ready (level)
//   pc_en, pc_redirect, *_en, *_flush   pipeline control (combinational)
//   fwd_a_sel, fwd_b_sel  00 regfile, 01 WB result, 10 MEM ALU result
//   stall_cycles  saturating count of cycles with pc_en=0
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       regwrite;
    logic       is_load;
  } ex_entry_t;

  // Past EX only the destination side is ever consulted, so the source
  // fields are not carried further down the scoreboard.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } mem_entry_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
  } wb_entry_t;

  typedef enum logic {ST_RUN = 1'b0, ST_FREEZE = 1'b1} state_t;

  state_t           state_q;
  ex_entry_t        ex_q, ex_d;
  mem_entry_t       mem_q, mem_d;
  wb_entry_t        wb_q, wb_d;
  logic             redirect_pending_q, redirect_pending_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze, redirect_go, load_use;
  logic ex_src, mem_src, wb_src;

  // Entering FREEZE and staying there both hinge on mem_busy being high.
  assign freeze      = mem_busy || ((state_q == ST_FREEZE) && mem_busy);
  assign redirect_go = !freeze && (ex_redirect || redirect_pending_q);

  assign ex_src  = ex_q.valid  && ex_q.regwrite  && (ex_q.rd  != 5'd0);
  assign mem_src = mem_q.valid && mem_q.regwrite && (mem_q.rd != 5'd0);
  assign wb_src  = wb_q.valid  && wb_q.regwrite  && (wb_q.rd  != 5'd0);

  assign load_use = ex_src && ex_q.is_load && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_q.rd)));

  // Control outputs, priority: reset > freeze > redirect > load-use > normal.
  always_comb begin
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (redirect_go) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push a bubble into ID/EX, let the load move on.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Scoreboard / redirect-pending / counter next state.
  always_comb begin
    ex_d               = ex_q;
    mem_d              = mem_q;
    wb_d               = wb_q;
    redirect_pending_d = redirect_pending_q;
    stall_cnt_d        = stall_cnt_q;
    if (freeze) begin
      // Remember a redirect that arrives while frozen; apply it on thaw.
      if (ex_redirect) redirect_pending_d = 1'b1;
    end else begin
      mem_d.valid    = ex_q.valid;
      mem_d.rd       = ex_q.rd;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.is_load  = ex_q.is_load;
      wb_d.valid     = mem_q.valid;
      wb_d.rd        = mem_q.rd;
      wb_d.regwrite  = mem_q.regwrite;
      if (redirect_go || load_use) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = id_valid;
        ex_d.rd       = id_rd;
        ex_d.rs1      = id_rs1;
        ex_d.rs2      = id_rs2;
        ex_d.uses_rs1 = id_uses_rs1;
        ex_d.uses_rs2 = id_uses_rs2;
        ex_d.regwrite = id_regwrite;
        ex_d.is_load  = id_is_load;
      end
      if (redirect_go) redirect_pending_d = 1'b0;
    end
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q            <= ST_RUN;
      ex_q               <= '0;
      mem_q              <= '0;
      wb_q               <= '0;
      redirect_pending_q <= 1'b0;
      stall_cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_RUN:    if (mem_busy)  state_q <= ST_FREEZE;
        ST_FREEZE: if (!mem_busy) state_q <= ST_RUN;
        default:   state_q <= ST_RUN;
      endcase
      ex_q               <= ex_d;
      mem_q              <= mem_d;
      wb_q               <= wb_d;
      redirect_pending_q <= redirect_pending_d;
      stall_cnt_q        <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

  // Operand forwarding, one identical selector per EX source operand.
  // A load in MEM has no ALU result to offer; it is caught by load-use.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [4:0] rs;
    logic       used;
    logic [1:0] sel;
    assign rs   = (gi == 0) ? ex_q.rs1 : ex_q.rs2;
    assign used = (gi == 0) ? ex_q.uses_rs1 : ex_q.uses_rs2;
    always_comb begin
      sel = 2'b00;
      if (rst && ex_q.valid && used) begin
        if (mem_src && !mem_q.is_load && (mem_q.rd == rs)) begin
          sel = 2'b10;
        end else if (wb_src && (wb_q.rd == rs)) begin
          sel = 2'b01;
        end
      end
    end
  end

  assign fwd_a_sel = g_fwd[0].sel;
  assign fwd_b_sel = g_fwd[1].sel;

endmodule
